// File: rtl/vram_rgb_dp_if.sv
// Bus bundle for vram_rgb_dp: scan-out read port, drawing-side write port and clear control.
// The master drives requests; the slave (the RAM) drives read data, wr_ready and busy.
interface vram_rgb_dp_if #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned COLOR_BITS = 1
);
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [COLOR_BITS-1:0]   red;
  logic [COLOR_BITS-1:0]   green;
  logic [COLOR_BITS-1:0]   blue;
  logic                    rd_valid;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [3*COLOR_BITS-1:0] wr_data;
  logic                    clr_req;
  logic [3*COLOR_BITS-1:0] clr_color;
  logic                    busy;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data, clr_req, clr_color,
    input  red, green, blue, rd_valid, wr_ready, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, clr_req, clr_color,
    output red, green, blue, rd_valid, wr_ready, busy
  );
endinterface

// File: rtl/vram_rgb_dp.sv
// Dual-port RGB video RAM: 2-cycle registered read port, valid/ready write port, frame clear engine.
// Optional macro VRAM_BYPASS_EN forwards a same-cycle write to a matching read (write-first).
module vram_rgb_dp #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned COLOR_BITS     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst,
  vram_rgb_dp_if.slave bus
);
  localparam int unsigned PixW = 3 * COLOR_BITS;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PixW-1:0]   color_q, color_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [PixW-1:0]   mem_wdata;
  logic [PixW-1:0]   mem_q [DEPTH];

  logic [PixW-1:0]   s1_raw_q, s1_raw_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_oor_q, s1_oor_d;
  logic              rd_valid_q, rd_valid_d;
  logic [PixW-1:0]   rgb_q, rgb_d;
`ifdef VRAM_BYPASS_EN
  logic              s1_fwd_q, s1_fwd_d;
  logic [PixW-1:0]   s1_fwd_data_q, s1_fwd_data_d;
`endif

  // Clear engine owns the write port while busy; nothing is written during reset.
  always_comb begin
    mem_waddr = (state_q == StClear) ? ptr_q : bus.wr_addr;
    mem_wdata = (state_q == StClear) ? color_q : bus.wr_data;
    mem_we    = rst && ((state_q == StClear) ||
                        (bus.wr_valid && (state_q == StIdle) && in_range(bus.wr_addr)));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    color_d = color_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
          color_d = bus.clr_color;
        end
      end
      StClear: begin
        if (ptr_q == LastPtr) state_d = StIdle;
        else                  ptr_d   = ptr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s1_raw_d = s1_raw_q;
    if (bus.rd_en) s1_raw_d = mem_q[bus.rd_addr[IdxW-1:0]];
    s1_valid_d = bus.rd_en;
    s1_oor_d   = !in_range(bus.rd_addr);
`ifdef VRAM_BYPASS_EN
    s1_fwd_d      = bus.rd_en && mem_we && (mem_waddr == bus.rd_addr) && in_range(bus.rd_addr);
    s1_fwd_data_d = mem_wdata;
`endif
    rd_valid_d = s1_valid_q;
    rgb_d      = rgb_q;
    if (s1_valid_q) begin
      if (s1_oor_q) rgb_d = '0;
`ifdef VRAM_BYPASS_EN
      else if (s1_fwd_q) rgb_d = s1_fwd_data_q;
`endif
      else rgb_d = s1_raw_q;
    end
  end

  // Storage and raw read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr[IdxW-1:0]] <= mem_wdata;
    s1_raw_q <= s1_raw_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CLEAR_ON_RESET ? StClear : StIdle;
      ptr_q         <= '0;
      color_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_oor_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rgb_q         <= '0;
`ifdef VRAM_BYPASS_EN
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      color_q       <= color_d;
      s1_valid_q    <= s1_valid_d;
      s1_oor_q      <= s1_oor_d;
      rd_valid_q    <= rd_valid_d;
      rgb_q         <= rgb_d;
`ifdef VRAM_BYPASS_EN
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
`endif
    end
  end

  assign bus.red      = rgb_q[PixW-1 -: COLOR_BITS];
  assign bus.green    = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign bus.blue     = rgb_q[COLOR_BITS-1:0];
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ready = (state_q == StIdle);
  assign bus.busy     = (state_q == StClear);
endmodule

// File: tb/tb_vram_rgb_dp.sv
// Self-checking bench for vram_rgb_dp: random reads/writes against a frame-array reference model,
// clear timing, handshake stalls, out-of-range addresses and reset behaviour.
module tb_vram_rgb_dp;
  localparam int unsigned AW = 14;
  localparam int unsigned D  = 12288;
  localparam int unsigned D2 = 64;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  vram_rgb_dp_if #(.ADDR_W(AW), .COLOR_BITS(1)) bus ();
  vram_rgb_dp_if #(.ADDR_W(AW), .COLOR_BITS(1)) bus2 ();

  vram_rgb_dp #(.ADDR_W(AW), .DEPTH(D), .COLOR_BITS(1), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  vram_rgb_dp #(.ADDR_W(AW), .DEPTH(D2), .COLOR_BITS(1), .CLEAR_ON_RESET(1'b0)) u_nc (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // Reference frame: one entry per pixel, updated by committed writes and completed clears.
  logic [2:0] ref_mem [D];
  logic [2:0] last_exp;

  function automatic logic [2:0] ref_rd(input int unsigned a);
    return (a < D) ? ref_mem[a] : 3'b000;
  endfunction

  task automatic ref_fill(input logic [2:0] c);
    for (int i = 0; i < int'(D); i++) ref_mem[i] = c;
  endtask

  function automatic logic [2:0] rgb();
    return {bus.red, bus.green, bus.blue};
  endfunction

  function automatic logic [2:0] rgb2();
    return {bus2.red, bus2.green, bus2.blue};
  endfunction

  task automatic idle_bus();
    bus.rd_en = 0; bus.rd_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 0; bus.clr_color = '0;
    bus2.rd_en = 0; bus2.rd_addr = '0; bus2.wr_valid = 0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.clr_req = 0; bus2.clr_color = '0;
  endtask

  // Called at a negedge; holds the request until accepted, returns at a negedge.
  task automatic write_px(input int unsigned a, input logic [2:0] d, output bit ok);
    int unsigned tmp;
    tmp = a;
    ok = 0;
    bus.wr_valid = 1; bus.wr_addr = tmp[AW-1:0]; bus.wr_data = d;
    for (int i = 0; i < int'(2 * D); i++) begin
      if (bus.wr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.wr_valid = 0;
    if (ok && a < D) ref_mem[a] = d;
  endtask

  task automatic read_px(input int unsigned a, output logic [2:0] d, output logic v);
    int unsigned tmp;
    tmp = a;
    bus.rd_en = 1; bus.rd_addr = tmp[AW-1:0];
    @(negedge clk);
    bus.rd_en = 0;
    @(negedge clk);
    d = rgb(); v = bus.rd_valid;
  endtask

  task automatic read2(input int unsigned a, output logic [2:0] d, output logic v);
    int unsigned tmp;
    tmp = a;
    bus2.rd_en = 1; bus2.rd_addr = tmp[AW-1:0];
    @(negedge clk);
    bus2.rd_en = 0;
    @(negedge clk);
    d = rgb2(); v = bus2.rd_valid;
  endtask

  task automatic test_reset();
    int cnt, bad;
    rst = 0;
    repeat (5) @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL rst_rgb got=%b exp=000", rgb()); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
    rst = 1;
    cnt = 0; bad = 0;
    for (int i = 0; i < int'(D) + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (bus.busy && bus.wr_ready) bad++;
      if (!bus.busy) break;
    end
    checks++; if (cnt != int'(D)) begin errors++; $display("FAIL rst_clear_len got=%0d exp=%0d", cnt, D); end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_clear_ready got=%0d exp=0", bad); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", bus.wr_ready); end
    ref_fill(3'b000);
    last_exp = 3'b000;
    bus.rd_en = 1; bus.rd_addr = 14'd384;
    @(negedge clk);
    bus.rd_en = 0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early got=%b exp=0", bus.rd_valid); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1 || rgb() !== 3'b000) begin errors++; $display("FAIL rd_384 got=%b/%b exp=1/000", bus.rd_valid, rgb()); end
  endtask

  task automatic test_write_read();
    bit ok; logic [2:0] d; logic v;
    write_px(1356, 3'b101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_1356_accept got=0 exp=1"); end
    read_px(1356, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b101) begin errors++; $display("FAIL rd_1356 got=%b/%b exp=1/101", v, d); end
    bus.rd_en = 1; bus.rd_addr = 14'd1356;
    @(negedge clk);
    bus.rd_addr = 14'd384;
    @(negedge clk);
    bus.rd_en = 0;
    checks++; if (bus.rd_valid !== 1'b1 || rgb() !== 3'b101) begin errors++; $display("FAIL b2b_first got=%b/%b exp=1/101", bus.rd_valid, rgb()); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1 || rgb() !== 3'b000) begin errors++; $display("FAIL b2b_second got=%b/%b exp=1/000", bus.rd_valid, rgb()); end
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0 || rgb() !== 3'b000) begin errors++; $display("FAIL b2b_hold got=%b/%b exp=0/000", bus.rd_valid, rgb()); end
    last_exp = 3'b000;
  endtask

  task automatic test_same_cycle();
    logic [2:0] old, exp, d; logic v;
    old = ref_rd(1923);
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL sc_ready got=%b exp=1", bus.wr_ready); end
    bus.wr_valid = 1; bus.wr_addr = 14'd1923; bus.wr_data = 3'b111;
    bus.rd_en = 1; bus.rd_addr = 14'd1923;
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_en = 0;
    ref_mem[1923] = 3'b111;
`ifdef VRAM_BYPASS_EN
    exp = 3'b111;
`else
    exp = old;
`endif
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1 || rgb() !== exp) begin errors++; $display("FAIL sc_collide got=%b/%b exp=1/%b", bus.rd_valid, rgb(), exp); end
    read_px(1923, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b111) begin errors++; $display("FAIL sc_followup got=%b/%b exp=1/111", v, d); end
    last_exp = 3'b111;
  endtask

  task automatic test_out_of_range();
    bit ok; logic [2:0] d; logic v;
    write_px(12300, 3'b111, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oor_wr_accept got=0 exp=1"); end
    read_px(12300 - 8192, d, v);
    checks++; if (v !== 1'b1 || d !== ref_rd(4108)) begin errors++; $display("FAIL oor_alias_4108 got=%b/%b exp=1/%b", v, d, ref_rd(4108)); end
    read_px(12300 - 12288, d, v);
    checks++; if (v !== 1'b1 || d !== ref_rd(12)) begin errors++; $display("FAIL oor_alias_12 got=%b/%b exp=1/%b", v, d, ref_rd(12)); end
    read_px(12300, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b000) begin errors++; $display("FAIL oor_rd got=%b/%b exp=1/000", v, d); end
    last_exp = 3'b000;
  endtask

  task automatic test_random_stream();
    localparam int N = 48;
    int unsigned wa [12];
    bit          en_h [N];
    int unsigned ad_h [N];
    bit ok; logic [2:0] exp;
    for (int i = 0; i < 12; i++) begin
      wa[i] = (i == 11) ? $urandom_range((1 << AW) - 1, D) : $urandom_range(D - 1, 0);
      write_px(wa[i], 3'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_wr_accept idx=%0d got=0 exp=1", i); end
    end
    for (int i = 0; i < N + 2; i++) begin
      if (i >= 2) begin
        if (en_h[i-2]) last_exp = ref_rd(ad_h[i-2]);
        exp = last_exp;
        checks++;
        if (bus.rd_valid !== en_h[i-2] || rgb() !== exp) begin
          errors++;
          $display("FAIL rnd_stream i=%0d addr=%0d got=%b/%b exp=%b/%b", i - 2, ad_h[i-2], bus.rd_valid, rgb(), en_h[i-2], exp);
        end
      end
      if (i < N) begin
        en_h[i] = ($urandom_range(3, 0) != 0);
        case ($urandom_range(2, 0))
          0:       ad_h[i] = wa[$urandom_range(11, 0)];
          1:       ad_h[i] = $urandom_range(D - 1, 0);
          default: ad_h[i] = $urandom_range((1 << AW) - 1, D);
        endcase
        bus.rd_en = en_h[i]; bus.rd_addr = ad_h[i][AW-1:0];
      end else begin
        bus.rd_en = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_with_write();
    int unsigned start, first_ready;
    int bad, stall;
    bit got;
    logic [2:0] d, old11000; logic v;
    bus.wr_valid = 1; bus.wr_addr = 14'd7745; bus.wr_data = 3'b100;
    bus.clr_req = 1; bus.clr_color = 3'b010;
    @(negedge clk);
    bus.wr_valid = 0; bus.clr_req = 0;
    start = cyc;
    ref_mem[7745] = 3'b100;
    old11000 = ref_rd(11000);
    checks++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_start got=%b/%b exp=1/0", bus.busy, bus.wr_ready); end
    read_px(7745, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b100) begin errors++; $display("FAIL clr_wr_commit got=%b/%b exp=1/100", v, d); end
    bad = 0;
    for (int i = 0; i < int'(D) && (cyc - start) < 7800; i++) begin
      @(negedge clk);
      if (bus.wr_ready) bad++;
    end
    read_px(7745, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b010) begin errors++; $display("FAIL clr_partial_7745 got=%b/%b exp=1/010", v, d); end
    read_px(11000, d, v);
    checks++; if (v !== 1'b1 || d !== old11000) begin errors++; $display("FAIL clr_partial_11000 got=%b/%b exp=1/%b", v, d, old11000); end
    bus.clr_req = 1; bus.clr_color = 3'b111;
    @(negedge clk);
    bus.clr_req = 0;
    bus.wr_valid = 1; bus.wr_addr = 14'd7745; bus.wr_data = 3'b100;
    stall = 0; got = 0; first_ready = 0;
    for (int i = 0; i < int'(2 * D); i++) begin
      if (bus.wr_ready) begin got = 1; first_ready = cyc; break; end
      if (!bus.busy) bad++;
      stall++;
      @(negedge clk);
    end
    @(negedge clk);
    bus.wr_valid = 0;
    checks++; if (!got || first_ready - start != D) begin errors++; $display("FAIL clr_len got=%0d exp=%0d", first_ready - start, D); end
    checks++; if (stall == 0 || bad != 0) begin errors++; $display("FAIL clr_stall stall=%0d bad=%0d exp >0 and 0", stall, bad); end
    ref_fill(3'b010);
    ref_mem[7745] = 3'b100;
    read_px(7745, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b100) begin errors++; $display("FAIL clr_stalled_wr got=%b/%b exp=1/100", v, d); end
    read_px(11000, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b010) begin errors++; $display("FAIL clr_no_relatch got=%b/%b exp=1/010", v, d); end
    read_px(D - 1, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b010) begin errors++; $display("FAIL clr_last_px got=%b/%b exp=1/010", v, d); end
    last_exp = 3'b010;
  endtask

  task automatic test_reset_mid_clear();
    int unsigned start, a;
    int cnt;
    logic [2:0] d; logic v;
    bus.clr_req = 1; bus.clr_color = 3'b011;
    @(negedge clk);
    bus.clr_req = 0;
    start = cyc;
    for (int i = 0; i < 200 && (cyc - start) < 100; i++) @(negedge clk);
    bus.rd_en = 1; bus.rd_addr = 14'd5;
    @(negedge clk);
    bus.rd_en = 0;
    rst = 0;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0 || rgb() !== 3'b000) begin errors++; $display("FAIL rmc_flush got=%b/%b exp=0/000", bus.rd_valid, rgb()); end
    checks++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rmc_busy got=%b/%b exp=1/0", bus.busy, bus.wr_ready); end
    @(negedge clk);
    rst = 1;
    cnt = 0;
    for (int i = 0; i < int'(D) + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (!bus.busy) break;
    end
    checks++; if (cnt != int'(D)) begin errors++; $display("FAIL rmc_rerun_len got=%0d exp=%0d", cnt, D); end
    ref_fill(3'b000);
    a = $urandom_range(D - 1, 0);
    read_px(a, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b000) begin errors++; $display("FAIL rmc_rd addr=%0d got=%b/%b exp=1/000", a, v, d); end
    last_exp = 3'b000;
  endtask

  task automatic test_no_clear_on_reset();
    int cnt;
    int unsigned start;
    logic [2:0] d; logic v;
    rst2 = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus2.busy !== 1'b0 || bus2.wr_ready !== 1'b1 || bus2.rd_valid !== 1'b0) begin errors++; $display("FAIL nc_rst got=%b/%b/%b exp=0/1/0", bus2.busy, bus2.wr_ready, bus2.rd_valid); end
    rst2 = 1;
    @(negedge clk);
    checks++; if (bus2.busy !== 1'b0 || bus2.wr_ready !== 1'b1) begin errors++; $display("FAIL nc_idle got=%b/%b exp=0/1", bus2.busy, bus2.wr_ready); end
    bus2.clr_req = 1; bus2.clr_color = 3'b101;
    @(negedge clk);
    bus2.clr_req = 0;
    cnt = 0;
    for (int i = 0; i < int'(D2) + 20; i++) begin
      if (bus2.wr_ready) break;
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != int'(D2)) begin errors++; $display("FAIL nc_clear_len got=%0d exp=%0d", cnt, D2); end
    read2(10, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b101) begin errors++; $display("FAIL nc_rd10 got=%b/%b exp=1/101", v, d); end
    read2(100, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b000) begin errors++; $display("FAIL nc_rd_oor got=%b/%b exp=1/000", v, d); end
    bus2.clr_req = 1; bus2.clr_color = 3'b010;
    @(negedge clk);
    bus2.clr_req = 0;
    start = cyc;
    for (int i = 0; i < 50 && (cyc - start) < 20; i++) @(negedge clk);
    rst2 = 0;
    @(negedge clk);
    rst2 = 1;
    checks++; if (bus2.busy !== 1'b0 || bus2.wr_ready !== 1'b1) begin errors++; $display("FAIL nc_abort got=%b/%b exp=0/1", bus2.busy, bus2.wr_ready); end
    read2(5, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b010) begin errors++; $display("FAIL nc_partial_5 got=%b/%b exp=1/010", v, d); end
    read2(50, d, v);
    checks++; if (v !== 1'b1 || d !== 3'b101) begin errors++; $display("FAIL nc_partial_50 got=%b/%b exp=1/101", v, d); end
  endtask

  initial begin
    idle_bus();
    last_exp = 3'b000;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_same_cycle();
    test_out_of_range();
    test_random_stream();
    test_clear_with_write();
    test_reset_mid_clear();
    test_no_clear_on_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vram_rgb_dp.md
Name: vram_rgb_dp

Overview:
Parametrised dual-port video RAM. It is the successor to the fixed 1-bit-per-channel pixel store.
- Pixels are stored as {red, green, blue}, each COLOR_BITS wide.
- A registered read port feeds the VGA scan-out.
- A valid/ready write port serves the drawing side.
- A built-in clear engine fills the whole frame with one colour.

Parameters:
ADDR_W, 14, width of the read and write address buses.
DEPTH, 16384, number of pixel words; must satisfy DEPTH <= 2**ADDR_W.
COLOR_BITS, 1, bits per colour channel.
CLEAR_ON_RESET, 1, if 1, the block starts a clear to colour 0 directly out of reset.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  synchronous, active-low reset.
rd_en  in  1  read request; accepted every cycle, no backpressure.
rd_addr  in  ADDR_W  read pixel address.
red  out  COLOR_BITS  red channel of the pixel read.
green  out  COLOR_BITS  green channel of the pixel read.
blue  out  COLOR_BITS  blue channel of the pixel read.
rd_valid  out  1  high when red/green/blue carry read data.
wr_valid  in  1  write request.
wr_ready  out  1  write port can accept.
wr_addr  in  ADDR_W  write pixel address.
wr_data  in  3*COLOR_BITS  pixel to write, packed {r,g,b}, r in the MSBs.
clr_req  in  1  one-cycle pulse requesting a frame clear.
clr_color  in  3*COLOR_BITS  fill colour, packed {r,g,b}.
busy  out  1  clear in progress.

Behaviour:
- Reset (rst low at a clk edge):
  - red, green, blue = 0; rd_valid = 0; read pipeline flushed.
  - FSM goes to CLEAR with colour 0 and ptr 0 if CLEAR_ON_RESET=1, otherwise to IDLE.
  - busy = CLEAR_ON_RESET.
  - Memory contents are not reset.
- Read pipeline:
  - rd_en sampled at edge N; red/green/blue and rd_valid=1 appear after edge N+2, i.e. 2-cycle latency.
  - Fully pipelined: one read per cycle.
  - rd_valid is a 2-stage delayed copy of rd_en.
  - Outputs hold their last value while rd_valid=0.
  - rd_addr >= DEPTH returns 0 on all channels, with rd_valid still asserted.
  - Reads are allowed in every state; during a clear they return the partially cleared frame.
- Write handshake:
  - Transfer occurs when wr_valid && wr_ready at an edge.
  - wr_ready = (state==IDLE), decoded from the state register.
  - A write with wr_addr >= DEPTH is accepted and discarded.
  - The master must hold wr_addr/wr_data stable while wr_valid && !wr_ready.
- FSM states:
  - IDLE: wr_ready=1, busy=0. clr_req=1 latches clr_color, sets ptr=0 and moves to CLEAR on the next edge.
  - CLEAR: wr_ready=0, busy=1. Each cycle writes the latched colour at ptr, then ptr++. The write at ptr==DEPTH-1 returns the FSM to IDLE.
  - A clear takes exactly DEPTH cycles.
  - ptr is ADDR_W bits wide and never wraps past DEPTH-1.
- Simultaneous and boundary events:
  - wr_valid and clr_req together in IDLE: the write is committed on that edge, then the clear starts. The clear overwrites the written pixel.
  - clr_req during CLEAR is ignored; there is no queueing and no colour relatch.
  - Reset mid-clear aborts the clear. ptr restarts from 0 if CLEAR_ON_RESET=1; otherwise the FSM sits in IDLE with a partially cleared frame.
- Read-during-write to the same address in the same cycle, from either the port write or the clear write: read-first, i.e. returns the old data.

Optional Feature:
- Macro: VRAM_BYPASS_EN.
- Defined: same-cycle read and write to the same in-range address returns the newly written data (port data or clear colour). A forwarding mux sits in read stage 1; latency is unchanged.
- Undefined: read-first behaviour as above, with no forwarding logic.

Test Plan:
- CLEAR_ON_RESET=1, rst low for 5 cycles, then released:
  - busy=1 and wr_ready=0 for exactly 16384 cycles, then busy=0 and wr_ready=1.
  - A read of addr 384 afterwards gives rgb=(0,0,0) and rd_valid=1, 2 cycles after rd_en.
- Write addr 1356 with data 3'b101, then rd_en at 1356:
  - red=1, green=0, blue=1 two cycles later.
  - Back-to-back reads of 1356 and 384 give 101 then 000 on consecutive cycles.
- Addr 1923 holds 000; write 111 and rd_en at 1923 in the same cycle:
  - Without the macro: output 000.
  - With VRAM_BYPASS_EN: output 111.
  - A follow-up read gives 111 in both builds.
- clr_req with clr_color=3'b010 while wr_valid is held with addr 7745, data 3'b100, in the same cycle:
  - The write commits; wr_ready=0 for 16384 cycles.
  - A read of 7745 during the clear at ptr>7745 gives 010.
  - A second write to 7745 issued mid-clear stalls, then commits when wr_ready returns; readback gives 100.
- DEPTH=12288:
  - Write 3'b111 to addr 12300: accepted, with no alias effect on addr 12300-8192 or addr 12300-12288.
  - Read of 12300 gives 000 with rd_valid=1.
  - A clear runs exactly 12288 cycles.
- Reset mid-clear at ptr≈100 with a read in flight:
  - rd_valid=0 and outputs=0 on the next edge.
  - CLEAR_ON_RESET=1: busy stays high and the clear reruns the full DEPTH cycles.
  - CLEAR_ON_RESET=0: busy=0 and wr_ready=1 immediately after release.
